// File: rtl/mpu_bus_monitor_pkg.sv
// Shared constants and types for the 6502 bus monitor: frame sync byte,
// default clocking, sequencer/serializer state encodings.
package mpu_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 32'd50_000_000;
    localparam int unsigned DEFAULT_BAUD   = 32'd500_000;
    localparam logic [7:0]  SYNC_BYTE      = 8'hA5;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_BYTE0 = 2'd1,
        SEQ_BYTE1 = 2'd2,
        SEQ_BYTE2 = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Byte to transmit for a given frame position of a held address
    function automatic logic [7:0] frame_byte(input seq_state_t st, input logic [15:0] addr);
        logic [7:0] b;
        case (st)
            SEQ_BYTE0: b = SYNC_BYTE;
            SEQ_BYTE1: b = addr[15:8];
            SEQ_BYTE2: b = addr[7:0];
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mpu_bus_monitor_uart_tx.sv
// 8N1 UART serializer with flow control: a byte starts only while busy is low,
// and once started it always runs to the end of its stop bit.
module uart_tx
    import mpu_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 32'd100
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    input  logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;

    tx_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             tx_r;
    logic             last_s;
    logic             done_s;

    // Bit-period end detection and byte-done strobe
    always_comb begin
        last_s = (cnt_r == CNT_W'(CLKS_PER_BIT - 32'd1));
        done_s = 1'b0;
        if ((state_r == TX_STOP) && last_s) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // Serializer state machine; tx is registered so the line never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= TX_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                TX_IDLE: begin
                    cnt_r     <= '0;
                    bit_idx_r <= 3'd0;
                    if (start && !busy) begin
                        shift_r <= data;
                        tx_r    <= 1'b0;
                        state_r <= TX_START;
                    end else begin
                        tx_r    <= 1'b1;
                    end
                end
                TX_START: begin
                    if (last_s) begin
                        cnt_r   <= '0;
                        tx_r    <= shift_r[0];
                        state_r <= TX_DATA;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (last_s) begin
                        cnt_r <= '0;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= TX_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (last_s) begin
                        cnt_r   <= '0;
                        state_r <= TX_IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= TX_IDLE;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign done = done_s;
    assign tx   = tx_r;

endmodule

// File: rtl/mpu_bus_monitor.sv
// Samples the 6502 address bus on each mpu_clk rise, buffers samples in a
// small FIFO and streams each one to the AVR as a 3-byte UART frame.
module mpu_bus_monitor
    import mpu_pkg::*;
#(
    parameter int unsigned CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int unsigned BAUD       = DEFAULT_BAUD,
    parameter int unsigned FIFO_DEPTH = 32'd4
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        mpu_clk,
    input  logic [15:0] addr_bus,
    input  logic        avr_rx_busy,
    output logic        avr_rx,
    output logic        overflow,
    output logic        tx_active
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned PW           = AW + 32'd1;

    logic [15:0]   addr_meta_r;
    logic [15:0]   addr_sync_r;
    logic          busy_meta_r;
    logic          busy_sync_r;
    logic          mpu_clk_q_r;
    logic [15:0]   mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic          overflow_r;
    logic          tx_active_r;
    seq_state_t    seq_state_r;
    logic [15:0]   hold_r;

    logic          rise_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic          byte_start_s;
    logic [7:0]    byte_data_s;
    logic          byte_done_s;
    logic          tx_s;

    // Two-flop synchronizers and mpu_clk edge-detect delay
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_meta_r <= 16'h0000;
            addr_sync_r <= 16'h0000;
            busy_meta_r <= 1'b0;
            busy_sync_r <= 1'b0;
            mpu_clk_q_r <= 1'b0;
        end else begin
            addr_meta_r <= addr_bus;
            addr_sync_r <= addr_meta_r;
            busy_meta_r <= avr_rx_busy;
            busy_sync_r <= busy_meta_r;
            mpu_clk_q_r <= mpu_clk;
        end
    end

    // FIFO status; a push into a full FIFO is accepted when a pop frees the slot
    always_comb begin
        rise_s  = mpu_clk & ~mpu_clk_q_r;
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s   = (seq_state_r == SEQ_IDLE) && !empty_s;
        push_s  = 1'b0;
        drop_s  = 1'b0;
        if (rise_s) begin
            push_s = !full_s || pop_s;
            drop_s = full_s && !pop_s;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
        byte_start_s = (seq_state_r != SEQ_IDLE);
        byte_data_s  = frame_byte(seq_state_r, hold_r);
    end

    // Sample storage; data needs no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= addr_sync_r;
        end
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Frame sequencer: pop into holding register, then emit three bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_state_r <= SEQ_IDLE;
            hold_r      <= 16'h0000;
            tx_active_r <= 1'b0;
        end else begin
            case (seq_state_r)
                SEQ_IDLE: begin
                    if (pop_s) begin
                        hold_r      <= mem_r[rd_ptr_r[AW-1:0]];
                        tx_active_r <= 1'b1;
                        seq_state_r <= SEQ_BYTE0;
                    end else begin
                        tx_active_r <= 1'b0;
                    end
                end
                SEQ_BYTE0: begin
                    if (byte_done_s) begin
                        seq_state_r <= SEQ_BYTE1;
                    end
                end
                SEQ_BYTE1: begin
                    if (byte_done_s) begin
                        seq_state_r <= SEQ_BYTE2;
                    end
                end
                SEQ_BYTE2: begin
                    if (byte_done_s) begin
                        tx_active_r <= 1'b0;
                        seq_state_r <= SEQ_IDLE;
                    end
                end
                default: begin
                    tx_active_r <= 1'b0;
                    seq_state_r <= SEQ_IDLE;
                end
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (byte_data_s),
        .start (byte_start_s),
        .busy  (busy_sync_r),
        .done  (byte_done_s),
        .tx    (tx_s)
    );

    assign avr_rx    = tx_s;
    assign overflow  = overflow_r;
    assign tx_active = tx_active_r;

endmodule

// File: tb/tb_mpu_bus_monitor.sv
// Directed bench for mpu_bus_monitor: a background 8N1 receiver decodes avr_rx
// with per-clock bit-width checking; scenario tasks compare against hand-built vectors.
module tb_mpu_bus_monitor;

    localparam int CPB = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        mpu_clk;
    logic [15:0] addr_bus;
    logic        avr_rx_busy;
    logic        avr_rx;
    logic        overflow;
    logic        tx_active;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rx_q[$];
    int         rx_glitch = 0;
    bit         rx_on = 1'b0;
    int         rx_pos = 0;
    logic       rx_cur = 1'b1;
    logic [7:0] rx_sh = 8'h00;

    mpu_bus_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .mpu_clk     (mpu_clk),
        .addr_bus    (addr_bus),
        .avr_rx_busy (avr_rx_busy),
        .avr_rx      (avr_rx),
        .overflow    (overflow),
        .tx_active   (tx_active)
    );

    always #5 clk = ~clk;

    // Background receiver: every bit must hold one level for exactly CPB clocks
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                rx_on = 1'b0;
            end else if (!rx_on) begin
                if (avr_rx === 1'b0) begin
                    rx_on  = 1'b1;
                    rx_pos = 0;
                    rx_cur = 1'b0;
                end
            end else begin
                rx_pos = rx_pos + 1;
                if ((rx_pos % CPB) == 0) begin
                    rx_cur = avr_rx;
                    if ((rx_pos / CPB) >= 1 && (rx_pos / CPB) <= 8)
                        rx_sh[(rx_pos / CPB) - 1] = avr_rx;
                end else if (avr_rx !== rx_cur) begin
                    rx_glitch = rx_glitch + 1;
                end
                if (rx_pos == 10 * CPB - 1) begin
                    rx_on = 1'b0;
                    if (rx_cur !== 1'b1) rx_glitch = rx_glitch + 1;
                    else rx_q.push_back(rx_sh);
                end
            end
        end
    end

    task automatic do_reset();
        rst         = 1'b1;
        mpu_clk     = 1'b0;
        avr_rx_busy = 1'b0;
        addr_bus    = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rx_q.delete();
        rx_glitch = 0;
    endtask

    task automatic mpu_rise(input logic [15:0] a);
        @(negedge clk);
        addr_bus = a;
        repeat (3) @(negedge clk);
        mpu_clk = 1'b1;
        @(negedge clk);
        mpu_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (rx_q.size() >= n) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lows;
        do_reset();
        n_tests++;
        if (avr_rx !== 1'b1) begin n_fail++; $display("FAIL reset_avr_rx got %b exp 1", avr_rx); end
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        n_tests++;
        if (tx_active !== 1'b0) begin n_fail++; $display("FAIL reset_tx_active got %b exp 0", tx_active); end
        lows = 0;
        repeat (20) begin @(negedge clk); if (avr_rx !== 1'b1) lows++; end
        n_tests++;
        if (lows != 0) begin n_fail++; $display("FAIL reset_idle_line got %0d low clks exp 0", lows); end
    endtask

    task automatic test_single_frame();
        bit to;
        logic [7:0] exp[$];
        logic [7:0] got;
        do_reset();
        exp = '{8'hA5, 8'h12, 8'h34};
        mpu_rise(16'h1234);
        wait_bytes(3, 4000, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL single_timeout got %0d bytes exp 3", rx_q.size()); end
        n_tests++;
        if (tx_active !== 1'b1) begin n_fail++; $display("FAIL single_active_stop got %b exp 1", tx_active); end
        @(negedge clk); #1;
        n_tests++;
        if (tx_active !== 1'b0) begin n_fail++; $display("FAIL single_active_drop got %b exp 0", tx_active); end
        for (int i = 0; i < 3; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_tests++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL single_byte%0d got %h exp %h", i, got, exp[i]); end
        end
        n_tests++;
        if (rx_glitch != 0) begin n_fail++; $display("FAIL single_bit_timing got %0d errors exp 0", rx_glitch); end
    endtask

    task automatic test_overflow();
        bit to;
        logic [7:0] exp[$];
        logic [7:0] got;
        do_reset();
        for (int i = 1; i <= 6; i++) mpu_rise(16'(i));
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        for (int i = 1; i <= 5; i++) begin
            exp.push_back(8'hA5); exp.push_back(8'h00); exp.push_back(8'(i));
        end
        wait_bytes(15, 16000, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL ovf_timeout got %0d bytes exp 15", rx_q.size()); end
        repeat (50) @(negedge clk);
        n_tests++;
        if (tx_active !== 1'b0) begin n_fail++; $display("FAIL ovf_no_sixth got tx_active %b exp 0", tx_active); end
        n_tests++;
        if (rx_q.size() != 15) begin n_fail++; $display("FAIL ovf_count got %0d exp 15", rx_q.size()); end
        for (int i = 0; i < 15; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_tests++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL ovf_byte%0d got %h exp %h", i, got, exp[i]); end
        end
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_busy_before();
        bit to;
        int lows;
        int k;
        logic [7:0] exp[$];
        logic [7:0] got;
        do_reset();
        exp = '{8'hA5, 8'h5A, 8'h3C};
        avr_rx_busy = 1'b1;
        repeat (4) @(negedge clk);
        mpu_rise(16'h5A3C);
        lows = 0;
        repeat (300) begin @(negedge clk); if (avr_rx !== 1'b1) lows++; end
        n_tests++;
        if (lows != 0) begin n_fail++; $display("FAIL busy_hold_line got %0d low clks exp 0", lows); end
        n_tests++;
        if (tx_active !== 1'b1) begin n_fail++; $display("FAIL busy_pending got %b exp 1", tx_active); end
        avr_rx_busy = 1'b0;
        k = 0;
        while (avr_rx !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        n_tests++;
        if (k < 3 || k > 5) begin n_fail++; $display("FAIL busy_release_latency got %0d clks exp 3..5", k); end
        wait_bytes(3, 4000, to);
        for (int i = 0; i < 3; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_tests++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL busy_byte%0d got %h exp %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_busy_mid_byte();
        bit to;
        int lows;
        int k;
        logic [7:0] exp[$];
        logic [7:0] got;
        do_reset();
        exp = '{8'hA5, 8'hBE, 8'hEF};
        mpu_rise(16'hBEEF);
        k = 0;
        while (!(rx_on && rx_pos >= 500) && k < 2000) begin @(negedge clk); k++; end
        avr_rx_busy = 1'b1;
        wait_bytes(1, 1500, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL midbusy_first_timeout got %0d bytes exp 1", rx_q.size()); end
        lows = 0;
        repeat (600) begin @(negedge clk); if (avr_rx !== 1'b1) lows++; end
        n_tests++;
        if (lows != 0 || rx_q.size() != 1) begin
            n_fail++; $display("FAIL midbusy_hold got %0d lows %0d bytes exp 0 lows 1 byte", lows, rx_q.size());
        end
        avr_rx_busy = 1'b0;
        wait_bytes(3, 4000, to);
        for (int i = 0; i < 3; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_tests++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL midbusy_byte%0d got %h exp %h", i, got, exp[i]); end
        end
        n_tests++;
        if (rx_glitch != 0) begin n_fail++; $display("FAIL midbusy_bit_timing got %0d errors exp 0", rx_glitch); end
    endtask

    task automatic test_reset_mid_frame();
        int lows;
        int k;
        int qn;
        do_reset();
        for (int i = 1; i <= 6; i++) mpu_rise(16'h1111 * 16'(i));
        n_tests++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_ovf got %b exp 1", overflow); end
        k = 0;
        while (!(rx_q.size() >= 1 && rx_on && rx_pos >= 400) && k < 3000) begin @(negedge clk); k++; end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (avr_rx !== 1'b1) begin n_fail++; $display("FAIL rstmid_avr_rx got %b exp 1", avr_rx); end
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_overflow got %b exp 0", overflow); end
        n_tests++;
        if (tx_active !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_active got %b exp 0", tx_active); end
        @(negedge clk);
        rst = 1'b0;
        qn = rx_q.size();
        lows = 0;
        repeat (3200) begin @(negedge clk); if (avr_rx !== 1'b1 || tx_active !== 1'b0) lows++; end
        n_tests++;
        if (lows != 0 || rx_q.size() != qn) begin
            n_fail++; $display("FAIL rstmid_quiet got %0d active clks %0d new bytes exp 0 0", lows, rx_q.size() - qn);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int k;
        logic [7:0] exp[$];
        logic [7:0] got;
        logic [15:0] a;
        do_reset();
        for (int i = 0; i < 5; i++) mpu_rise(16'hC000 + 16'(i));
        for (int i = 0; i < 5; i++) begin
            addr_bus = 16'hD000 + 16'(i);
            k = 0;
            while (tx_active !== 1'b1 && k < 4000) begin @(negedge clk); k++; end
            while (tx_active !== 1'b0 && k < 4000) begin @(negedge clk); k++; end
            n_tests++;
            if (k >= 4000) begin n_fail++; $display("FAIL b2b_boundary%0d_timeout got %0d clks exp <4000", i, k); end
            mpu_clk = 1'b1;
            @(negedge clk);
            mpu_clk = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            a = (i < 5) ? (16'hC000 + 16'(i)) : (16'hD000 + 16'(i - 5));
            exp.push_back(8'hA5); exp.push_back(a[15:8]); exp.push_back(a[7:0]);
        end
        wait_bytes(30, 20000, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL b2b_timeout got %0d bytes exp 30", rx_q.size()); end
        n_tests++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got %b exp 0", overflow); end
        for (int i = 0; i < 30; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_tests++;
            if (got !== exp[i]) begin n_fail++; $display("FAIL b2b_byte%0d got %h exp %h", i, got, exp[i]); end
        end
        n_tests++;
        if (rx_glitch != 0) begin n_fail++; $display("FAIL b2b_bit_timing got %0d errors exp 0", rx_glitch); end
    endtask

    initial begin
        rst         = 1'b1;
        mpu_clk     = 1'b0;
        addr_bus    = 16'h0000;
        avr_rx_busy = 1'b0;
        test_reset();
        test_single_frame();
        test_overflow();
        test_busy_before();
        test_busy_mid_byte();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mpu_bus_monitor.md
MPU_BUS_MONITOR -- requirements
Module: mpu_bus_monitor

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency.
REQ-002 SHALL have parameter BAUD, default 500000, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (100 at defaults).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of buffered address samples (power of two).
REQ-004 SHALL have port: clk  input  1  system clock; sole clock domain.
REQ-005 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port: mpu_clk  input  1  6502 clock from the clock divider, registered in clk domain.
REQ-007 SHALL have port: addr_bus  input  16  6502 address bus, asynchronous.
REQ-008 SHALL have port: avr_rx_busy  input  1  AVR flow control, high means do not start a byte; asynchronous.
REQ-009 SHALL have port: avr_rx  output  1  UART TX line to AVR.
REQ-010 SHALL have port: overflow  output  1  sticky: a sample was dropped.
REQ-011 SHALL have port: tx_active  output  1  high while a frame is in progress.

Function
REQ-012 SHALL pass addr_bus and avr_rx_busy through 2-flop synchronizers.
REQ-013 SHALL detect a rising edge of mpu_clk with one delay register: rise = mpu_clk & ~mpu_clk_q.
REQ-014 SHALL, in the rise cycle, push synchronized addr_bus into the FIFO if not full.
REQ-015 SHALL, on rise while FIFO full, drop the sample, leave FIFO contents unchanged, and set overflow next cycle.
REQ-016 SHALL handle simultaneous push and pop in one cycle, with occupancy unchanged, including when full.
REQ-017 SHALL send each sample as a 3-byte frame: 0xA5, addr[15:8], addr[7:0].
REQ-018 SHALL use frame sequencer states IDLE, BYTE0, BYTE1, BYTE2.
REQ-019 SHALL, in IDLE with FIFO non-empty, pop one entry into a holding register, then go to BYTE0.
REQ-020 SHALL advance the sequencer only on byte-done from the serializer; after BYTE2 it returns to IDLE.
REQ-021 SHALL start each byte only when synchronized avr_rx_busy is low; while high, hold avr_rx=1 and wait.
REQ-022 SHALL not abort a byte already started when busy rises.
REQ-023 SHALL serialize in states IDLE, START, DATA, STOP with 8N1 framing: start 0, 8 data bits LSB first, stop 1.
REQ-024 SHALL hold each bit exactly CLKS_PER_BIT clocks, giving 10*CLKS_PER_BIT clocks per byte.
REQ-025 SHALL raise byte-done for one cycle at the end of STOP.
REQ-026 SHALL allow a new byte to start the cycle after byte-done when permitted.
REQ-027 SHALL keep FIFO pointers log2(FIFO_DEPTH)+1 bits wide, using the MSB to distinguish full from empty, and wrap modulo 2*FIFO_DEPTH.
REQ-028 SHALL assert tx_active from the pop cycle through the byte-done of BYTE2.

Reset
REQ-029 SHALL, on rst high at a clk edge, set avr_rx=1, overflow=0, tx_active=0, FIFO empty, sequencer IDLE, serializer IDLE, and clear synchronizer and mpu_clk_q to 0.
REQ-030 SHALL, on reset mid-frame, abandon the frame immediately without completing the byte; avr_rx is 1 the cycle after reset.
REQ-031 SHALL clear overflow only by reset.

Structure
REQ-032 SHALL place the sync byte 0xA5 and default BAUD/CLK_HZ constants in a shared package mpu_pkg.
REQ-033 SHALL implement the serializer (REQ-021..REQ-026) as sub-module uart_tx: data in, start, busy, done, tx.
REQ-034 SHALL implement the FIFO and frame sequencer inline.

Verification
REQ-035 SHALL verify: reset, then a single mpu_clk rise with addr_bus=0x1234 -> avr_rx bytes 0xA5,0x12,0x34; each bit 100 clks; tx_active drops after the stop bit.
REQ-036 SHALL verify: 6 mpu_clk rises during one frame, addresses 0x0001..0x0006, depth 4 -> first 5 samples transmitted in order (one in holding, 4 in FIFO), 0x0006 dropped, overflow=1.
REQ-037 SHALL verify: avr_rx_busy held high before a frame -> avr_rx stays 1; release -> 0xA5 start bit begins within 3 clks of the synchronized low.
REQ-038 SHALL verify: busy raised mid-byte -> current byte completes unaltered, and the next byte is held until busy low.
REQ-039 SHALL verify: rst pulsed mid-DATA of byte1 -> avr_rx=1 next cycle, FIFO empty, overflow=0, and no further bytes without new rises.
REQ-040 SHALL verify: push and pop in the same cycle with FIFO full -> no overflow and no sample lost, across pointer wrap (more than 8 samples).
